// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the default WIDTH/DIGITS sizing.
package bcd_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DIGITS = 3;

  // Two-bit encoding leaves two unused codes; the FSM sends them to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_e;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for bin_to_bcd_seq.
//   start   : conversion request (master -> slave)
//   bin_in  : unsigned binary operand (master -> slave)
//   busy    : conversion in progress (slave -> master)
//   done    : one-cycle pulse, new result on bcd_out (slave -> master)
//   bcd_out : packed BCD result, LS digit in [3:0] (slave -> master)
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
);

  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (output start, bin_in, input busy, done, bcd_out);
  modport slave  (input start, bin_in, output busy, done, bcd_out);

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
//   d_i : 4-bit digit before correction
//   d_o : 4-bit corrected digit
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, shift-and-add-3, one bit per clock.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of bin_to_bcd_seq_if (start/bin_in in,
//           busy/done/bcd_out out)
// A start seen in IDLE captures bin_in; WIDTH edges later the result is
// loaded into bcd_out and done pulses for one cycle.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                reset,
  bin_to_bcd_seq_if.slave     bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              done_q, done_d;

  logic [BW-1:0]     corr;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3 u_add3 (
        .d_i (scratch_q[4*g +: 4]),
        .d_o (corr[4*g +: 4])
      );
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    opnd_d    = opnd_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opnd_d    = bus.bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, opnd_d} = {corr, opnd_q} << 1;
        cnt_d               = cnt_q + CW'(1);
        // Last iteration: publish the fully shifted scratch in one step so
        // bcd_out never shows a partial value.
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = scratch_d;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      opnd_q    <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      opnd_q    <= opnd_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  // Outputs come straight from flops: no combinational path from start.
  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: expected BCD values are queued
// when a conversion is requested and compared when done pulses.
module tb_bin_to_bcd_seq;

  logic clk;
  logic reset;

  bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus ();

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [11:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // Scoreboard consumer; also guards the busy/done exclusivity.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done && bus.busy) chk("done_and_busy", 1, 0);
      if (bus.done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else chk("bcd_out", {20'd0, bus.bcd_out}, {20'd0, sb.pop_front()});
      end
    end
  end

  // One conversion: start pulse, then wait (bounded) for done.
  // Leaves time at posedge+#1 of the done cycle.
  task automatic conv(input int v, input logic hold_chk, input logic [11:0] prev,
                      output int lat, output int busy_cyc);
    bus.bin_in = 8'(v);
    bus.start  = 1'b1;
    sb.push_back(to_bcd(v));
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.bin_in = 8'($urandom);    // must not disturb the running conversion
    lat = 0; busy_cyc = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cyc++;
      if (hold_chk) chk("hold_prev", {20'd0, bus.bcd_out}, {20'd0, prev});
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) chk("done_timeout", 1, 0);
  endtask

  initial begin
    int lat, bc, last, gap;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    reset      = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_bcd",  bus.bcd_out, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // 255: latency and busy length
    conv(255, 1'b0, 12'h0, lat, bc);
    chk("lat_255", lat, 8);
    chk("busy_255", bc, 8);
    chk("busy_at_done", bus.busy, 0);

    // 255 -> 3: old result must hold until done
    conv(3, 1'b1, 12'h255, lat, bc);

    // full sweep, back-to-back
    for (int v = 0; v < 256; v++) conv(v, 1'b0, 12'h0, lat, bc);
    @(posedge clk); #1;

    // start again while busy must be ignored
    bus.bin_in = 8'd42; bus.start = 1'b1;
    sb.push_back(to_bcd(42));
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.bin_in = 8'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin @(posedge clk); #1; lat++; end
    if (lat >= 40) chk("done_timeout_42", 1, 0);
    repeat (15) @(posedge clk);
    #1 chk("bcd_042_held", bus.bcd_out, 12'h042);

    // held-high start, operand switched at each done
    bus.bin_in = 8'd199; bus.start = 1'b1;
    sb.push_back(to_bcd(199));
    last = 0; gap = 0;
    for (int n = 0; n < 4; n++) begin
      lat = 0;
      @(posedge clk); #1; lat++;
      while (!bus.done && lat < 40) begin @(posedge clk); #1; lat++; end
      if (lat >= 40) chk("done_timeout_held", 1, 0);
      if (n > 0) chk("held_period", lat, 9);
      if (n < 3) begin
        bus.bin_in = (n % 2 == 0) ? 8'd50 : 8'd199;
        sb.push_back(to_bcd(int'(bus.bin_in)));
      end else begin
        bus.start = 1'b0;
      end
    end
    @(posedge clk); #1;

    // reset in the middle of a conversion of 128
    bus.bin_in = 8'd128; bus.start = 1'b1;
    sb.push_back(to_bcd(128));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_bcd",  bus.bcd_out, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("postrst_idle", bus.busy, 0);
    conv(128, 1'b1, 12'h000, lat, bc);
    chk("lat_128", lat, 8);

    repeat (12) @(posedge clk);
    #1 chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
